skew_feeder: RTL and testbench

- Reader side of the per-row operand FIFOs that feed the systolic PE array.
- On command, pops K operands from each of ROWS row FIFOs with a diagonal skew: row r starts r cycles after row 0.
- Presents the operands, registered, to the west edge of the PE array, with a per-row valid and zero-fill outside each row's window.
- Stalls the whole wavefront if any row due to pop has an empty FIFO, so the diagonal alignment is never broken.

---
 rtl/systolic_pkg.sv | 30 +++
 rtl/feeder_row_slice.sv | 63 ++++++
 rtl/skew_feeder.sv | 116 +++++++++++
 tb/tb_skew_feeder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared constants for the systolic-array operand feeder.
//               Holds the feeder FSM state encoding, the default geometry
//               parameters and a helper that sizes the skew counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Feeder FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FEED   = 2'd1;
  localparam logic [1:0] DONE_S = 2'd2;

  // Default array geometry
  localparam int DEF_ROWS      = 32;
  localparam int DEF_ROWS_LOG2 = 5;
  localparam int DEF_BWIDTH    = 8;
  localparam int DEF_LEN_W     = 8;

  // Skew counter width: one bit of headroom over K + ROWS so the last
  // diagonal index K+ROWS-2 (and its increment) never wraps.
  function automatic int t_width(input int len_w, input int rows_log2);
    return len_w + rows_log2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_row_slice.sv
`default_nettype none
// ============================================================================
// Module      : feeder_row_slice
// Description : One row of the skewed feeder. Decides whether this row is
//               inside its pop window for the current skew index and holds
//               the registered operand / valid presented to the PE array.
// Ports       : clk, rst_n      - clock, async active-low reset
//               state           - feeder FSM state
//               t, k            - skew counter and latched vector length
//               pop             - this row's pop enable (after stall gating)
//               d_in            - this row's FIFO head data
//               need            - row is inside its window this cycle
//               a_out, a_valid  - registered operand and valid
// Revision    : 1.0 - initial release
// ============================================================================
module feeder_row_slice
  import systolic_pkg::*;
#(
  parameter int ROW    = 0,
  parameter int BWIDTH = DEF_BWIDTH,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int TW     = t_width(DEF_LEN_W, DEF_ROWS_LOG2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        state,
  input  logic [TW-1:0]     t,
  input  logic [LEN_W-1:0]  k,
  input  logic              pop,
  input  logic [BWIDTH-1:0] d_in,
  output logic              need,
  output logic [BWIDTH-1:0] a_out,
  output logic              a_valid
);

  localparam logic [TW-1:0] ROW_T = TW'(ROW);

  logic [TW-1:0] w_k_ext;
  logic [TW-1:0] w_win_end;

  assign w_k_ext   = {{(TW-LEN_W){1'b0}}, k};
  assign w_win_end = ROW_T + w_k_ext;

  // Row r is active for skew indices r .. r+K-1
  assign need = (state == FEED) && (t >= ROW_T) && (t < w_win_end);

  // Zero-fill whenever the row does not pop so downstream accumulation
  // sees a neutral operand on idle and stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out   <= '0;
      a_valid <= 1'b0;
    end else if (pop) begin
      a_out   <= d_in;
      a_valid <= 1'b1;
    end else begin
      a_out   <= '0;
      a_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : skew_feeder
// Description : Reader side of the per-row operand FIFOs feeding a systolic
//               PE array. Pops K operands from each row with a diagonal
//               skew (row r starts r cycles after row 0) and stalls the
//               whole wavefront if any due row is empty.
// Ports       : CLK, RSTn  - clock, async active-low reset
//               START, LEN - command strobe and vector length K
//               IS_EMPTY   - per-row FIFO empty flags
//               D_in       - per-row FIFO head data
//               POPE       - per-row pop enables (combinational)
//               A_out      - registered operands to the PE west edge
//               A_valid    - registered per-row operand valid
//               BUSY, DONE - command in progress / end-of-command pulse
// Revision    : 1.0 - initial release
// ============================================================================
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int ROWS_LOG2 = DEF_ROWS_LOG2,
  parameter int BWIDTH    = DEF_BWIDTH,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   START,
  input  logic [LEN_W-1:0]       LEN,
  input  logic [ROWS-1:0]        IS_EMPTY,
  input  logic [ROWS*BWIDTH-1:0] D_in,
  output logic [ROWS-1:0]        POPE,
  output logic [ROWS*BWIDTH-1:0] A_out,
  output logic [ROWS-1:0]        A_valid,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int TW = t_width(LEN_W, ROWS_LOG2);
  localparam logic [TW-1:0] ROWS_M2 = TW'(ROWS - 2);

  logic [1:0]       r_state;
  logic [TW-1:0]    r_t;
  logic [LEN_W-1:0] r_k;

  logic [ROWS-1:0]  w_need;
  logic             w_stall;
  logic [TW-1:0]    w_last_t;

  // Any due row with an empty FIFO freezes every row, keeping the diagonal
  // alignment intact.
  assign w_stall  = |(w_need & IS_EMPTY);
  assign POPE     = w_need & ~{ROWS{w_stall}};
  assign w_last_t = {{(TW-LEN_W){1'b0}}, r_k} + ROWS_M2;

  assign BUSY = (r_state != IDLE);
  assign DONE = (r_state == DONE_S);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            if (LEN != '0) begin
              r_k     <= LEN;
              r_t     <= '0;
              r_state <= FEED;
            end else begin
              r_state <= DONE_S;
            end
          end
        end
        FEED: begin
          if (!w_stall) begin
            r_t <= r_t + TW'(1);
            if (r_t == w_last_t) begin
              r_state <= DONE_S;
            end
          end
        end
        DONE_S: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    feeder_row_slice #(
      .ROW    (r),
      .BWIDTH (BWIDTH),
      .LEN_W  (LEN_W),
      .TW     (TW)
    ) u_slice (
      .clk     (CLK),
      .rst_n   (RSTn),
      .state   (r_state),
      .t       (r_t),
      .k       (r_k),
      .pop     (POPE[r]),
      .d_in    (D_in[r*BWIDTH +: BWIDTH]),
      .need    (w_need[r]),
      .a_out   (A_out[r*BWIDTH +: BWIDTH]),
      .a_valid (A_valid[r])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_skew_feeder
// Description : Directed testbench for skew_feeder with ROWS=4, BWIDTH=8,
//               LEN_W=8. Row r FIFO head shows 16*r + (pops so far).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skew_feeder;

  logic        CLK;
  logic        RSTn;
  logic        START;
  logic [7:0]  LEN;
  logic [3:0]  IS_EMPTY;
  logic [31:0] D_in;
  logic [3:0]  POPE;
  logic [31:0] A_out;
  logic [3:0]  A_valid;
  logic        BUSY;
  logic        DONE;

  logic [3:0]  force_empty;
  logic        clr;
  int          ptr [4];

  int n_checks;
  int n_errors;

  skew_feeder #(
    .ROWS      (4),
    .ROWS_LOG2 (2),
    .BWIDTH    (8),
    .LEN_W     (8)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .START    (START),
    .LEN      (LEN),
    .IS_EMPTY (IS_EMPTY),
    .D_in     (D_in),
    .POPE     (POPE),
    .A_out    (A_out),
    .A_valid  (A_valid),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // FIFO model: unbounded, emptiness only under bench control.
  always @(posedge CLK) begin
    for (int r = 0; r < 4; r++) begin
      if (clr) ptr[r] <= 0;
      else if (POPE[r]) ptr[r] <= ptr[r] + 1;
    end
  end

  assign IS_EMPTY = force_empty;

  always_comb begin
    D_in = '0;
    for (int r = 0; r < 4; r++) D_in[r*8 +: 8] = 8'(16*r + ptr[r]);
  end

  // Hand-computed vectors, K=3 unstalled (index = cycle after acceptance)
  localparam logic [3:0]  E1_POPE [8] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
  localparam logic [3:0]  E1_VAL  [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
  localparam logic [31:0] E1_OUT  [8] = '{32'h0, 32'h0, 32'h00001001, 32'h00201102,
                                          32'h30211200, 32'h31220000, 32'h32000000, 32'h0};
  // K=3 with row 2 empty for cycles 2..4
  localparam logic [3:0]  E2_POPE [11] = '{4'h1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
  localparam logic [3:0]  E2_VAL  [11] = '{4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
  localparam logic [31:0] E2_OUT  [11] = '{32'h0, 32'h0, 32'h00001001, 32'h0, 32'h0, 32'h0,
                                           32'h00201102, 32'h30211200, 32'h31220000, 32'h32000000, 32'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [7:0] len);
    START = 1'b1;
    LEN   = len;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic clear_fifos();
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
  endtask

  int done_at;
  int n_done;

  initial begin
    n_checks = 0;
    n_errors = 0;
    RSTn = 1'b0; START = 1'b0; LEN = '0; force_empty = '0; clr = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset state
    chk("rst POPE",    32'(POPE),    32'h0);
    chk("rst A_valid", 32'(A_valid), 32'h0);
    chk("rst A_out",   A_out,        32'h0);
    chk("rst BUSY",    32'(BUSY),    32'h0);
    chk("rst DONE",    32'(DONE),    32'h0);
    RSTn = 1'b1;
    @(negedge CLK);
    clr = 1'b0;

    // K=3, unstalled; out-of-window rows reported empty must be ignored
    clear_fifos();
    start_cmd(8'd3);
    for (int j = 0; j < 8; j++) begin
      force_empty = (j <= 2) ? 4'b1000 : 4'b0001;
      #1;
      chk($sformatf("k3 POPE c%0d", j),    32'(POPE),    32'(E1_POPE[j]));
      chk($sformatf("k3 A_valid c%0d", j), 32'(A_valid), 32'(E1_VAL[j]));
      chk($sformatf("k3 A_out c%0d", j),   A_out,        E1_OUT[j]);
      chk($sformatf("k3 BUSY c%0d", j),    32'(BUSY),    (j <= 6) ? 32'h1 : 32'h0);
      chk($sformatf("k3 DONE c%0d", j),    32'(DONE),    (j == 6) ? 32'h1 : 32'h0);
      @(negedge CLK);
    end
    force_empty = '0;
    for (int r = 0; r < 4; r++) chk($sformatf("k3 pops row%0d", r), 32'(ptr[r]), 32'd3);

    // K=3, row 2 empty for three cycles from t=2
    clear_fifos();
    start_cmd(8'd3);
    for (int j = 0; j < 11; j++) begin
      force_empty = (j >= 2 && j <= 4) ? 4'b0100 : 4'b0000;
      #1;
      chk($sformatf("stall POPE c%0d", j),    32'(POPE),    32'(E2_POPE[j]));
      chk($sformatf("stall A_valid c%0d", j), 32'(A_valid), 32'(E2_VAL[j]));
      chk($sformatf("stall A_out c%0d", j),   A_out,        E2_OUT[j]);
      chk($sformatf("stall BUSY c%0d", j),    32'(BUSY),    (j <= 9) ? 32'h1 : 32'h0);
      chk($sformatf("stall DONE c%0d", j),    32'(DONE),    (j == 9) ? 32'h1 : 32'h0);
      @(negedge CLK);
    end
    force_empty = '0;

    // LEN=0: straight to DONE, no pops
    clear_fifos();
    start_cmd(8'd0);
    #1;
    chk("len0 POPE", 32'(POPE), 32'h0);
    chk("len0 BUSY", 32'(BUSY), 32'h1);
    chk("len0 DONE", 32'(DONE), 32'h1);
    @(negedge CLK);
    chk("len0 BUSY after", 32'(BUSY), 32'h0);
    chk("len0 DONE after", 32'(DONE), 32'h0);
    chk("len0 pops",       32'(ptr[0] + ptr[1] + ptr[2] + ptr[3]), 32'h0);

    // START pulsed mid-FEED is ignored
    clear_fifos();
    start_cmd(8'd3);
    for (int j = 0; j < 8; j++) begin
      START = (j == 2);
      LEN   = (j == 2) ? 8'd5 : 8'd0;
      #1;
      chk($sformatf("restart POPE c%0d", j), 32'(POPE), 32'(E1_POPE[j]));
      chk($sformatf("restart DONE c%0d", j), 32'(DONE), (j == 6) ? 32'h1 : 32'h0);
      @(negedge CLK);
    end
    START = 1'b0;
    chk("restart BUSY end", 32'(BUSY), 32'h0);
    for (int r = 0; r < 4; r++) chk($sformatf("restart pops row%0d", r), 32'(ptr[r]), 32'd3);

    // Asynchronous reset at t=2
    clear_fifos();
    start_cmd(8'd3);
    repeat (2) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("arst POPE",    32'(POPE),    32'h0);
    chk("arst A_valid", 32'(A_valid), 32'h0);
    chk("arst A_out",   A_out,        32'h0);
    chk("arst BUSY",    32'(BUSY),    32'h0);
    chk("arst DONE",    32'(DONE),    32'h0);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk($sformatf("post-rst POPE c%0d", j), 32'(POPE), 32'h0);
      chk($sformatf("post-rst BUSY c%0d", j), 32'(BUSY), 32'h0);
      @(negedge CLK);
    end
    chk("arst pops row0", 32'(ptr[0]), 32'd2);
    chk("arst pops row1", 32'(ptr[1]), 32'd1);
    chk("arst pops row2", 32'(ptr[2]), 32'd0);
    chk("arst pops row3", 32'(ptr[3]), 32'd0);

    // K=255: t runs to 257 without wrap, DONE once
    clear_fifos();
    start_cmd(8'd255);
    done_at = -1;
    n_done  = 0;
    for (int j = 0; j < 300; j++) begin
      if (DONE) begin
        n_done++;
        if (done_at < 0) done_at = j;
        chk("k255 A_valid at DONE", 32'(A_valid),     32'h8);
        chk("k255 A_out3 at DONE",  32'(A_out[31:24]), 32'h2E);
      end
      @(negedge CLK);
    end
    chk("k255 DONE cycle", 32'(done_at), 32'd258);
    chk("k255 DONE count", 32'(n_done),  32'd1);
    for (int r = 0; r < 4; r++) chk($sformatf("k255 pops row%0d", r), 32'(ptr[r]), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
